data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised, byte-addressable data memory for the datapath MEM stage.
//  - Loads and stores of byte, half and word size; loads sign- or zero-extend
//  - Valid/ready request port; read response one cycle after acceptance
//  - Misaligned and reserved-size accesses are flagged
//  - Optional post-reset clear sequencer
// PARAMETERS
//  DEPTH   32  number of 32-bit words; power of two, >=2
//  ADDR_W  32  width of the byte address
//  IDX_W   $clog2(DEPTH)  local: word-index width
// PORTS
//  clk           in   1       clock, rising edge
//  reset_n       in   1       asynchronous reset, active low
//  req_valid     in   1       request present
//  req_ready     out  1       block can accept a request this cycle
//  req_write     in   1       1=store, 0=load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1       load: 1 zero-extends, 0 sign-extends
//  address       in   ADDR_W  byte address
//  write_data    in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid    out  1       one-cycle pulse: load data valid
//  read_data     out  32      load result; holds its value until the next load response
//  misaligned    out  1       one-cycle pulse, same cycle as the response slot
//  busy          out  1       clear sequence running
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - resp_valid=0, read_data=0, misaligned=0
//    - State goes to CLEAR (macro on) or IDLE (macro off)
//  - Accept: a request is taken at a rising edge when req_valid && req_ready.
//    - req_ready = (state != CLEAR)
//    - Back-to-back acceptance every cycle is supported.
//  - Word index = address[IDX_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
//  - Lane = address[1:0]
//  - Alignment check:
//    - half with address[0]=1, word with address[1:0]!=0, and size 11 are misaligned
//  - Store (aligned): committed at the accepting edge, using the byte lanes only:
//    - byte: write_data[7:0] goes to lane
//    - half: write_data[15:0] goes to lanes {lane+1, lane}
//    - word: all 32 bits
//    - Untouched bytes keep their value.
//    - No resp_valid pulse.
//  - Load (aligned), accepted at edge N:
//    - At edge N the byte/half/word at the lane is extracted, extended and registered into read_data.
//    - resp_valid=1 during cycle N+1.
//  - Misaligned request, accepted at edge N:
//    - No memory change.
//    - misaligned=1 during cycle N+1.
//    - If it is a load: resp_valid=1 and read_data=0 in that cycle.
//  - Store then load to the same word on consecutive cycles: the load returns the new data (no stale read).
//  - Idle cycles: resp_valid=0 and misaligned=0; read_data holds.
//  - FSM:
//    - CLEAR -> IDLE when clr_ptr==DEPTH-1 (that word is zeroed in the same cycle)
//    - IDLE is the only steady state; responses are registered flags, not states
// CONFIGURATION
//  MEM_CLEAR_EN defined:
//    - After reset release, CLEAR zeroes one word per cycle, index 0..DEPTH-1.
//    - busy=1 and req_ready=0 for exactly DEPTH cycles, then IDLE.
//    - reset_n low during CLEAR restarts the sequence at index 0.
//  MEM_CLEAR_EN undefined:
//    - No CLEAR state; busy is tied to 0.
//    - req_ready=1 from the first edge after reset release.
//    - Memory contents are uninitialised (X in simulation).
// TESTING
//  - Reset/clear (macro on, DEPTH=32): release reset_n
//    -> busy=1, req_ready=0 for 32 cycles; then a word load of 0x00 returns 0x00000000.
//  - Word store 0xDEADBEEF to 0x10, then word load of 0x10 on the next cycle
//    -> resp_valid one cycle after acceptance, read_data=0xDEADBEEF.
//  - Byte store 0x80 to 0x13, then loads of 0x13:
//    - lb -> 0xFFFFFF80
//    - lbu -> 0x00000080
//    - lw of 0x10 -> 0x80ADBEEF
//  - Misaligned accesses:
//    - lh at 0x11 -> misaligned=1, resp_valid=1, read_data=0
//    - sw at 0x12 -> misaligned=1, memory unchanged (lw 0x10 still 0x80ADBEEF)
//  - Address wrap (DEPTH=32): sw 0x12345678 to 0x84, then lw 0x04 -> 0x12345678.
//  - Reset mid-operation:
//    - reset_n low for 1 cycle during CLEAR at index 10 -> clear restarts, busy held 32 more cycles
//    - reset_n low while a load is pending -> resp_valid=0, read_data=0

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory for the MEM stage: sized loads/stores, registered load response.
// Optional post-reset word-by-word clear sequencer enabled by defining MEM_CLEAR_EN.
module data_mem_ctrl #(
  parameter  int DEPTH  = 32,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              misaligned,
  output logic              busy
);

  logic [3:0][7:0] r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic [1:0]       w_lane_hi;
  logic             w_mis;
  logic             w_acc;
  logic             w_st;
  logic             w_ld;
  logic             w_clr;
  logic [IDX_W-1:0] w_clr_ptr;
  logic [31:0]      w_word;
  logic [31:0]      w_shift;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Upper address bits are deliberately ignored so accesses wrap modulo 4*DEPTH.
  assign w_unused  = &{1'b0, address[ADDR_W-1:IDX_W+2]};
  assign w_idx     = address[IDX_W+1:2];
  assign w_lane    = address[1:0];
  assign w_lane_hi = {w_lane[1], 1'b1};

  always_comb begin
    w_mis = 1'b0;
    case (req_size)
      2'b01:   w_mis = w_lane[0];
      2'b10:   w_mis = (w_lane != 2'b00);
      2'b11:   w_mis = 1'b1;
      default: w_mis = 1'b0;
    endcase
  end

  assign w_acc = req_valid && req_ready;
  assign w_st  = w_acc && req_write && !w_mis;
  assign w_ld  = w_acc && !req_write;

`ifdef MEM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_clr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr = 1'b1;
        if (r_clr_ptr == IDX_W'(DEPTH-1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_clr_ptr = r_clr_ptr;
  assign req_ready = (r_state != S_CLEAR);
  assign busy      = (r_state == S_CLEAR);
`else
  assign w_clr     = 1'b0;
  assign w_clr_ptr = '0;
  assign req_ready = 1'b1;
  assign busy      = 1'b0;
`endif

  // Clear owns the array while running; requests are blocked then, so no conflict.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[w_clr_ptr] <= '0;
    end else if (w_st) begin
      case (req_size)
        2'b00: r_mem[w_idx][w_lane] <= write_data[7:0];
        2'b01: begin
          r_mem[w_idx][w_lane]    <= write_data[7:0];
          r_mem[w_idx][w_lane_hi] <= write_data[15:8];
        end
        default: r_mem[w_idx] <= write_data;
      endcase
    end
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_rdata = w_word;
    case (req_size)
      2'b00:   w_rdata = {{24{~req_unsigned & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_rdata = {{16{~req_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: w_rdata = w_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      read_data  <= '0;
    end else begin
      resp_valid <= w_ld;
      misaligned <= w_acc && w_mis;
      if (w_ld) read_data <= w_mis ? 32'd0 : w_rdata;
    end
  end

endmodule
